// File: rtl/pgm_gfx_ddram_responder_if.sv
// Graphics-ROM read bus: video-side word handshake plus the
// DDRAM Avalon burst master, as seen from the responder.
interface pgm_gfx_ddram_responder_if;
  logic        ddram_rd;
  logic [28:0] ddram_addr;
  logic        ddram_busy;
  logic [63:0] ddram_dout;
  logic        ddram_dout_ready;
  logic [28:0] avl_addr;
  logic [7:0]  avl_burstcnt;
  logic [7:0]  avl_be;
  logic        avl_rd;
  logic        avl_busy;
  logic [63:0] avl_dout;
  logic        avl_dout_ready;

  modport slave (
    input  ddram_rd, ddram_addr,
    input  avl_busy, avl_dout, avl_dout_ready,
    output ddram_busy, ddram_dout, ddram_dout_ready,
    output avl_addr, avl_burstcnt, avl_be, avl_rd
  );

  modport master (
    output ddram_rd, ddram_addr,
    output avl_busy, avl_dout, avl_dout_ready,
    input  ddram_busy, ddram_dout, ddram_dout_ready,
    input  avl_addr, avl_burstcnt, avl_be, avl_rd
  );
endinterface

// File: rtl/pgm_gfx_ddram_responder.sv
// PGM graphics-ROM responder: one 4-word line buffer in front of
// a 4-beat DDRAM Avalon burst reader.
module pgm_gfx_ddram_responder #(
  parameter logic [28:0] BASE_ADDR  = 29'h0300_0000,
  parameter int unsigned LINE_WORDS = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic invalidate_i,
  pgm_gfx_ddram_responder_if.slave bus
);

  localparam int IW = $clog2(LINE_WORDS);
  localparam int TW = 29 - IW;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_FILL,
    S_RESP,
    S_RELEASE
  } state_e;

  state_e         state_q;
  logic           busy_q;
  logic [63:0]    dout_q;
  logic           rdy_q;
  logic [28:0]    avl_addr_q;
  logic           avl_rd_q;
  logic           valid_q;
  logic [TW-1:0]  tag_q;
  logic [28:0]    req_q;
  logic [IW-1:0]  beat_q;
  logic           inval_q;
  logic [63:0]    line_q [LINE_WORDS];

  logic [IW-1:0]  rd_idx;
  logic [IW-1:0]  req_idx;
  logic           hit;
  logic [28:0]    miss_addr_d;
  logic [63:0]    fill_word_d;
  logic           last_beat;

  assign rd_idx  = bus.ddram_addr[IW-1:0];
  assign req_idx = req_q[IW-1:0];

  // A coincident invalidate forces the lookup to miss.
  assign hit = valid_q && !invalidate_i &&
               (tag_q == bus.ddram_addr[28:IW]);

  assign miss_addr_d = BASE_ADDR +
                       {bus.ddram_addr[28:IW], {IW{1'b0}}};

  assign last_beat = (beat_q == IW'(LINE_WORDS - 1));

  assign fill_word_d = (req_idx == beat_q) ? bus.avl_dout
                                           : line_q[req_idx];

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      busy_q     <= 1'b0;
      dout_q     <= '0;
      rdy_q      <= 1'b0;
      avl_addr_q <= '0;
      avl_rd_q   <= 1'b0;
      valid_q    <= 1'b0;
      tag_q      <= '0;
      req_q      <= '0;
      beat_q     <= '0;
      inval_q    <= 1'b0;
      for (int i = 0; i < LINE_WORDS; i++) line_q[i] <= '0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (invalidate_i) valid_q <= 1'b0;
          if (bus.ddram_rd) begin
            req_q  <= bus.ddram_addr;
            busy_q <= 1'b1;
            if (hit) begin
              dout_q  <= line_q[rd_idx];
              rdy_q   <= 1'b1;
              state_q <= S_RESP;
            end else begin
              avl_addr_q <= miss_addr_d;
              avl_rd_q   <= 1'b1;
              state_q    <= S_ISSUE;
            end
          end
        end
        S_ISSUE: begin
          if (invalidate_i) inval_q <= 1'b1;
          if (!bus.avl_busy) begin
            avl_rd_q <= 1'b0;
            beat_q   <= '0;
            state_q  <= S_FILL;
          end
        end
        S_FILL: begin
          if (invalidate_i) inval_q <= 1'b1;
          if (bus.avl_dout_ready) begin
            line_q[beat_q] <= bus.avl_dout;
            beat_q         <= beat_q + 1'b1;
            if (last_beat) begin
              tag_q   <= req_q[28:IW];
              valid_q <= !inval_q && !invalidate_i;
              inval_q <= 1'b0;
              dout_q  <= fill_word_d;
              rdy_q   <= 1'b1;
              state_q <= S_RESP;
            end
          end
        end
        S_RESP: begin
          if (invalidate_i) valid_q <= 1'b0;
          rdy_q   <= 1'b0;
          state_q <= S_RELEASE;
        end
        S_RELEASE: begin
          if (invalidate_i) valid_q <= 1'b0;
          // Hold off until the requester drops its level request.
          if (!bus.ddram_rd) begin
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.ddram_busy       = busy_q;
  assign bus.ddram_dout       = dout_q;
  assign bus.ddram_dout_ready = rdy_q;
  assign bus.avl_addr         = avl_addr_q;
  assign bus.avl_rd           = avl_rd_q;
  assign bus.avl_burstcnt     = 8'(LINE_WORDS);
  assign bus.avl_be           = 8'hFF;

endmodule

// File: tb/tb_pgm_gfx_ddram_responder.sv
// Directed bench for pgm_gfx_ddram_responder: misses, hits,
// waitrequest, held request, invalidate, address wrap, reset.
module tb_pgm_gfx_ddram_responder;

  logic clk;
  logic reset;
  logic inval;
  logic inval_w;

  pgm_gfx_ddram_responder_if v ();
  pgm_gfx_ddram_responder_if w ();

  pgm_gfx_ddram_responder #(
    .BASE_ADDR (29'h0300_0000),
    .LINE_WORDS(4)
  ) u_dut (
    .clk         (clk),
    .reset       (reset),
    .invalidate_i(inval),
    .bus         (v.slave)
  );

  pgm_gfx_ddram_responder #(
    .BASE_ADDR (29'h1FFF_FFFC),
    .LINE_WORDS(4)
  ) u_wrap (
    .clk         (clk),
    .reset       (reset),
    .invalidate_i(inval_w),
    .bus         (w.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk;
  int n_fail;
  int acc_cnt;
  int rdhi_cnt;
  int resp_cnt;

  always @(posedge clk) begin
    if (v.avl_rd) rdhi_cnt <= rdhi_cnt + 1;
    if (v.avl_rd && !v.avl_busy) acc_cnt <= acc_cnt + 1;
    if (v.ddram_dout_ready) resp_cnt <= resp_cnt + 1;
  end

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic fill(input logic [63:0] base);
    for (int i = 0; i < 4; i++) begin
      v.avl_dout       = base + 64'(i);
      v.avl_dout_ready = 1'b1;
      @(negedge clk);
    end
    v.avl_dout_ready = 1'b0;
  endtask

  task automatic release_rd();
    v.ddram_rd = 1'b0;
    cyc(2);
  endtask

  localparam logic [63:0] D = 64'hD0D0_0000_0000_0000;
  localparam logic [63:0] E = 64'hE0E0_0000_0000_0000;
  localparam logic [63:0] F = 64'hF0F0_0000_0000_0000;
  localparam logic [63:0] G = 64'hCAFE_0000_0000_0000;

  int a0, h0, r0;

  initial begin
    n_chk = 0; n_fail = 0;
    acc_cnt = 0; rdhi_cnt = 0; resp_cnt = 0;
    reset = 1'b1; inval = 1'b0; inval_w = 1'b0;
    v.ddram_rd = 1'b0; v.ddram_addr = '0;
    v.avl_busy = 1'b0; v.avl_dout = '0; v.avl_dout_ready = 1'b0;
    w.ddram_rd = 1'b0; w.ddram_addr = '0;
    w.avl_busy = 1'b1; w.avl_dout = '0; w.avl_dout_ready = 1'b0;
    cyc(3);
    chk("rst_busy", 64'(v.ddram_busy), 64'd0);
    chk("rst_rdy", 64'(v.ddram_dout_ready), 64'd0);
    chk("rst_dout", v.ddram_dout, 64'd0);
    chk("rst_avl_rd", 64'(v.avl_rd), 64'd0);
    chk("rst_avl_addr", 64'(v.avl_addr), 64'd0);
    reset = 1'b0;
    cyc(1);

    // cold miss
    a0 = acc_cnt; h0 = rdhi_cnt; r0 = resp_cnt;
    v.ddram_addr = 29'h12345; v.ddram_rd = 1'b1;
    w.ddram_addr = 29'h8; w.ddram_rd = 1'b1;
    cyc(1);
    chk("miss_avl_rd", 64'(v.avl_rd), 64'd1);
    chk("miss_avl_addr", 64'(v.avl_addr), 64'h0301_2344);
    chk("miss_burstcnt", 64'(v.avl_burstcnt), 64'd4);
    chk("miss_be", 64'(v.avl_be), 64'hFF);
    chk("miss_busy", 64'(v.ddram_busy), 64'd1);
    chk("wrap_avl_addr", 64'(w.avl_addr), 64'h4);
    chk("wrap_avl_rd", 64'(w.avl_rd), 64'd1);
    w.ddram_rd = 1'b0;
    cyc(1);
    chk("miss_rd_drop", 64'(v.avl_rd), 64'd0);
    fill(D);
    chk("miss_rdy", 64'(v.ddram_dout_ready), 64'd1);
    chk("miss_dout", v.ddram_dout, D + 64'd1);
    chk("miss_resp_busy", 64'(v.ddram_busy), 64'd1);
    release_rd();
    chk("miss_idle", 64'(v.ddram_busy), 64'd0);
    chk("miss_acc", 64'(acc_cnt - a0), 64'd1);
    chk("miss_rdhi", 64'(rdhi_cnt - h0), 64'd1);
    chk("miss_resp", 64'(resp_cnt - r0), 64'd1);

    // hit with held request
    a0 = acc_cnt; r0 = resp_cnt;
    v.ddram_addr = 29'h12347; v.ddram_rd = 1'b1;
    cyc(1);
    chk("hit_rdy", 64'(v.ddram_dout_ready), 64'd1);
    chk("hit_dout", v.ddram_dout, D + 64'd3);
    chk("hit_busy", 64'(v.ddram_busy), 64'd1);
    chk("hit_avl_rd", 64'(v.avl_rd), 64'd0);
    cyc(3);
    chk("held_busy", 64'(v.ddram_busy), 64'd1);
    chk("held_dout", v.ddram_dout, D + 64'd3);
    v.ddram_rd = 1'b0;
    cyc(1);
    chk("held_idle", 64'(v.ddram_busy), 64'd0);
    chk("held_resp", 64'(resp_cnt - r0), 64'd1);
    chk("held_acc", 64'(acc_cnt - a0), 64'd0);
    cyc(1);

    // waitrequest
    a0 = acc_cnt;
    v.avl_busy = 1'b1;
    v.ddram_addr = 29'h40; v.ddram_rd = 1'b1;
    for (int k = 0; k < 5; k++) begin
      cyc(1);
      chk($sformatf("wait_rd%0d", k), 64'(v.avl_rd), 64'd1);
      chk($sformatf("wait_addr%0d", k), 64'(v.avl_addr),
          64'h0300_0040);
    end
    v.avl_busy = 1'b0;
    cyc(1);
    chk("wait_accepted", 64'(v.avl_rd), 64'd0);
    chk("wait_acc", 64'(acc_cnt - a0), 64'd1);
    fill(E);
    chk("wait_dout", v.ddram_dout, E);
    release_rd();

    // invalidate during fill
    a0 = acc_cnt;
    v.ddram_addr = 29'h82; v.ddram_rd = 1'b1;
    cyc(2);
    v.avl_dout = F; v.avl_dout_ready = 1'b1; cyc(1);
    v.avl_dout = F + 64'd1; cyc(1);
    v.avl_dout_ready = 1'b0; inval = 1'b1; cyc(1);
    inval = 1'b0;
    v.avl_dout = F + 64'd2; v.avl_dout_ready = 1'b1; cyc(1);
    v.avl_dout = F + 64'd3; cyc(1);
    v.avl_dout_ready = 1'b0;
    chk("inv_rdy", 64'(v.ddram_dout_ready), 64'd1);
    chk("inv_dout", v.ddram_dout, F + 64'd2);
    release_rd();
    v.ddram_rd = 1'b1;
    cyc(1);
    chk("inv_remiss", 64'(v.avl_rd), 64'd1);
    chk("inv_remiss_rdy", 64'(v.ddram_dout_ready), 64'd0);
    cyc(1);
    fill(G);
    chk("refill_dout", v.ddram_dout, G + 64'd2);
    release_rd();
    chk("inv_acc", 64'(acc_cnt - a0), 64'd2);
    a0 = acc_cnt;
    v.ddram_addr = 29'h83; v.ddram_rd = 1'b1;
    cyc(1);
    chk("refill_hit", v.ddram_dout, G + 64'd3);
    chk("refill_hit_rdy", 64'(v.ddram_dout_ready), 64'd1);
    release_rd();
    chk("refill_hit_acc", 64'(acc_cnt - a0), 64'd0);

    // invalidate coincident with a hit sample, then reset mid-fill
    v.ddram_rd = 1'b1; inval = 1'b1;
    cyc(1);
    inval = 1'b0;
    chk("coinc_miss", 64'(v.avl_rd), 64'd1);
    chk("coinc_rdy", 64'(v.ddram_dout_ready), 64'd0);
    cyc(1);
    v.avl_dout = D; v.avl_dout_ready = 1'b1; cyc(2);
    v.avl_dout_ready = 1'b0;
    reset = 1'b1;
    cyc(1);
    chk("rst2_busy", 64'(v.ddram_busy), 64'd0);
    chk("rst2_rdy", 64'(v.ddram_dout_ready), 64'd0);
    chk("rst2_dout", v.ddram_dout, 64'd0);
    chk("rst2_avl_rd", 64'(v.avl_rd), 64'd0);
    chk("rst2_avl_addr", 64'(v.avl_addr), 64'd0);
    chk("rst2_wrap_rd", 64'(w.avl_rd), 64'd0);
    reset = 1'b0; v.ddram_rd = 1'b0;
    cyc(1);
    r0 = resp_cnt;
    v.avl_dout = E; v.avl_dout_ready = 1'b1; cyc(2);
    v.avl_dout_ready = 1'b0; cyc(2);
    chk("stray_resp", 64'(resp_cnt - r0), 64'd0);
    chk("stray_busy", 64'(v.ddram_busy), 64'd0);
    chk("stray_dout", v.ddram_dout, 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
